// File: rtl/acq_pkg.sv
// Shared constants and helpers for the acquisition packer.
// Build option: ACQ_PEAK_DET_EN enables the min/max peak-detect mode.
package acq_pkg;

  // Values of the mode input / mode_q register
  localparam logic ACQ_MODE_SAMPLE = 1'b0;
  localparam logic ACQ_MODE_PEAK   = 1'b1;

  // Bit offset of slot s of channel c inside a packed output word
  function automatic int acq_slot_off(input int c, input int s, input int pack, input int dw);
    return (c * pack + s) * dw;
  endfunction

endpackage

// File: rtl/acq_dec_ctr.sv
// Decimation counter: registers the ratio (0 maps to 1) and raises tick
// once every div_q run cycles. restart forces the count back to zero and
// suppresses the tick on that edge.
module acq_dec_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        restart,
  input  logic [31:0] div_n,
  output logic        tick
);

  logic [31:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d;

  // Ratio of zero behaves as one
  always_comb begin
    div_d = (div_n == 32'd0) ? 32'd1 : div_n;
  end

  // >= rather than == so that lowering div_q mid-window ticks at once instead of wrapping
  always_comb begin
    tick = run && !restart && (cnt_q >= div_q - 32'd1);
  end

  // Count run cycles, clearing on tick or restart
  always_comb begin
    cnt_d = cnt_q;
    if (restart || tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Ratio and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 32'd1;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acq_pack_path.sv
// Acquisition packer: decimates NCH sample streams, optionally reduces each
// decimation window to a min/max pair, and packs PACK slots per channel into
// one FIFO word with a one-cycle write strobe and sticky overflow flag.
// Build option: ACQ_PEAK_DET_EN builds the peak-detect mode (PACK must then
// be even); without it the mode input is ignored.
module acq_pack_path
  import acq_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int DW   = 8,
  parameter  int PACK = 4,
  localparam int OW   = NCH * PACK * DW
) (
  input  logic              data_clk,
  input  logic              cnt_clr,
  input  logic              run,
  input  logic              mode,
  input  logic [31:0]       div_n,
  input  logic [NCH*DW-1:0] din,
  input  logic              fifo_full,
  input  logic              ovf_clr,
  output logic [OW-1:0]     dataout,
  output logic              wr_en,
  output logic              ovf
);

  localparam int PW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(PACK - 1);

  logic          mode_chg;
  logic          restart;
  logic          tick;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] shadow_q, shadow_d;
  logic          done_q, done_d;
  logic [OW-1:0] dataout_q, dataout_d;
  logic          wr_en_q, wr_en_d;
  logic          ovf_q, ovf_d;

`ifdef ACQ_PEAK_DET_EN
  localparam logic [PW-1:0] PTR_LAST2 = PW'(PACK - 2);

  logic              mode_q;
  logic [NCH*DW-1:0] win_lo;
  logic [NCH*DW-1:0] win_hi;

  // Registered mode; a change restarts the partial word
  always_ff @(posedge data_clk or negedge cnt_clr) begin
    if (!cnt_clr) begin
      mode_q <= ACQ_MODE_SAMPLE;
    end else begin
      mode_q <= mode;
    end
  end

  assign mode_chg = (mode != mode_q);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_acc
      logic [DW-1:0] smp;
      logic [DW-1:0] lo, hi;
      logic [DW-1:0] mn_q, mn_d;
      logic [DW-1:0] mx_q, mx_d;

      assign smp = din[gi*DW +: DW];
      assign lo  = (smp < mn_q) ? smp : mn_q;
      assign hi  = (smp > mx_q) ? smp : mx_q;
      assign win_lo[gi*DW +: DW] = lo;
      assign win_hi[gi*DW +: DW] = hi;

      // Track window min/max, reloading after each tick or restart
      always_comb begin
        mn_d = lo;
        mx_d = hi;
        if (restart || tick) begin
          mn_d = '1;
          mx_d = '0;
        end
      end

      // Accumulator registers
      always_ff @(posedge data_clk or negedge cnt_clr) begin
        if (!cnt_clr) begin
          mn_q <= '1;
          mx_q <= '0;
        end else begin
          mn_q <= mn_d;
          mx_q <= mx_d;
        end
      end
    end
  endgenerate
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign mode_chg    = 1'b0;
`endif

  assign restart = !run || mode_chg;

  acq_dec_ctr u_dec_ctr (
    .clk     (data_clk),
    .rst_n   (cnt_clr),
    .run     (run),
    .restart (restart),
    .div_n   (div_n),
    .tick    (tick)
  );

  // Fill slots on each tick; flag completion when the last slot is written
  always_comb begin
    ptr_d    = ptr_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    if (restart) begin
      ptr_d    = '0;
      shadow_d = '0;
    end else if (tick) begin
`ifdef ACQ_PEAK_DET_EN
      if (mode_q == ACQ_MODE_PEAK) begin
        for (int c = 0; c < NCH; c++) begin
          shadow_d[acq_slot_off(c, int'(ptr_q), PACK, DW) +: DW]     = win_lo[c*DW +: DW];
          shadow_d[acq_slot_off(c, int'(ptr_q) + 1, PACK, DW) +: DW] = win_hi[c*DW +: DW];
        end
        if (ptr_q == PTR_LAST2) begin
          ptr_d  = '0;
          done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + PW'(2);
        end
      end else
`endif
      begin
        for (int c = 0; c < NCH; c++) begin
          shadow_d[acq_slot_off(c, int'(ptr_q), PACK, DW) +: DW] = din[c*DW +: DW];
        end
        if (ptr_q == PTR_LAST) begin
          ptr_d  = '0;
          done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
    end
  end

  // Emit a completed word one edge later; a full FIFO drops the strobe and sets ovf
  always_comb begin
    dataout_d = done_q ? shadow_q : dataout_q;
    wr_en_d   = done_q && !fifo_full;
    ovf_d     = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (done_q && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  // Packing and output state
  always_ff @(posedge data_clk or negedge cnt_clr) begin
    if (!cnt_clr) begin
      ptr_q     <= '0;
      shadow_q  <= '0;
      done_q    <= 1'b0;
      dataout_q <= '0;
      wr_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      shadow_q  <= shadow_d;
      done_q    <= done_d;
      dataout_q <= dataout_d;
      wr_en_q   <= wr_en_d;
      ovf_q     <= ovf_d;
    end
  end

  assign dataout = dataout_q;
  assign wr_en   = wr_en_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_acq_pack_path.sv
// Directed bench for acq_pack_path at NCH=4, DW=8, PACK=4.
// Peak-detect steps are built only when ACQ_PEAK_DET_EN is defined.
module tb_acq_pack_path;

  logic         data_clk = 1'b0;
  logic         cnt_clr;
  logic         run;
  logic         mode;
  logic [31:0]  div_n;
  logic [31:0]  din;
  logic         fifo_full;
  logic         ovf_clr;
  logic [127:0] dataout;
  logic         wr_en;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 data_clk = ~data_clk;

  acq_pack_path #(.NCH(4), .DW(8), .PACK(4)) dut (
    .data_clk  (data_clk),
    .cnt_clr   (cnt_clr),
    .run       (run),
    .mode      (mode),
    .div_n     (div_n),
    .din       (din),
    .fifo_full (fifo_full),
    .ovf_clr   (ovf_clr),
    .dataout   (dataout),
    .wr_en     (wr_en),
    .ovf       (ovf)
  );

  // One line per FIFO write
  always @(negedge data_clk) begin
    if (wr_en) $display("write: dataout=%h ovf=%b", dataout, ovf);
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Channel c carries b + 0x10*c; one clock edge, then outputs are sampled 1 time unit later
  task automatic apply(input logic [7:0] b);
    for (int c = 0; c < 4; c++) din[c*8 +: 8] = b + 8'(16 * c);
    @(posedge data_clk);
    #1;
  endtask

  // Expected word when ch0 slots hold v0..v3 and channel c is offset by 0x10*c
  function automatic logic [127:0] exp_word(input logic [7:0] v0, input logic [7:0] v1,
                                            input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0]   v [4];
    logic [127:0] w;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    w = '0;
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 4; s++)
        w[(c*4 + s)*8 +: 8] = v[s] + 8'(16 * c);
    return w;
  endfunction

  initial begin
    cnt_clr = 1'b0; run = 1'b0; mode = 1'b0; fifo_full = 1'b0; ovf_clr = 1'b0;
    div_n = 32'd1; din = '0;

    // Reset state
    @(posedge data_clk); #1;
    chk_word("reset_dataout", dataout, 128'h0);
    chk_bit("reset_wr_en", wr_en, 1'b0);
    chk_bit("reset_ovf", ovf, 1'b0);
    #1 cnt_clr = 1'b1;
    apply(8'h00);

    // Sample mode, div 1: strobe every 4 cycles, one cycle after the 4th sample
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply(8'(i));
      chk_bit($sformatf("s1_wr_en_%0d", i), wr_en, (i % 4 == 0) && (i > 0));
      if (i == 4) begin
        chk_word("s1_ch0_word0", {96'h0, dataout[31:0]}, {96'h0, 32'h03020100});
        chk_word("s1_word0", dataout, exp_word(8'h00, 8'h01, 8'h02, 8'h03));
      end
      if (i == 8) chk_word("s1_word1", dataout, exp_word(8'h04, 8'h05, 8'h06, 8'h07));
    end
    // Pending word still emits while run drops
    run = 1'b0;
    apply(8'h55);
    chk_bit("s1_pending_wr_en", wr_en, 1'b1);
    chk_word("s1_pending_word", dataout, exp_word(8'h0c, 8'h0d, 8'h0e, 8'h0f));
    apply(8'h56);
    chk_bit("s1_wr_en_low", wr_en, 1'b0);
    chk_word("s1_hold", dataout, exp_word(8'h0c, 8'h0d, 8'h0e, 8'h0f));

    // Decimation by 3
    div_n = 32'd3;
    apply(8'h00);
    run = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      apply(8'(i));
      chk_bit($sformatf("d3_wr_en_%0d", i), wr_en, i == 13);
    end
    chk_word("d3_word", dataout, exp_word(8'h03, 8'h06, 8'h09, 8'h0c));
    run = 1'b0;
    apply(8'h00);

    // div_n = 0 behaves as 1
    div_n = 32'd0;
    apply(8'h00);
    run = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      apply(8'h20 + 8'(i));
      chk_bit($sformatf("d0_wr_en_%0d", i), wr_en, i == 4);
    end
    chk_word("d0_word", dataout, exp_word(8'h20, 8'h21, 8'h22, 8'h23));
    run = 1'b0;
    apply(8'h00);

    // Ratio lowered from 10 to 2 mid-count: ticks immediately, no wrap
    div_n = 32'd10;
    apply(8'h00);
    run = 1'b1;
    for (int i = 1; i <= 5; i++) apply(8'h40 + 8'(i));
    div_n = 32'd2;
    for (int i = 6; i <= 14; i++) begin
      apply(8'h40 + 8'(i));
      chk_bit($sformatf("dc_wr_en_%0d", i), wr_en, i == 14);
    end
    chk_word("dc_word", dataout, exp_word(8'h47, 8'h49, 8'h4b, 8'h4d));
    run = 1'b0;
    div_n = 32'd1;
    apply(8'h00);

`ifdef ACQ_PEAK_DET_EN
    // Peak detect, div 4: windows {5,200,3,90} then {7,7,7,7}
    mode = 1'b1;
    div_n = 32'd4;
    apply(8'h00);
    run = 1'b1;
    apply(8'd5); apply(8'd200); apply(8'd3); apply(8'd90);
    apply(8'd7); apply(8'd7); apply(8'd7); apply(8'd7);
    chk_bit("pk_wr_en_early", wr_en, 1'b0);
    apply(8'd0);
    chk_bit("pk_wr_en", wr_en, 1'b1);
    chk_word("pk_ch0", {96'h0, dataout[31:0]}, {96'h0, 32'h0707c803});
    chk_word("pk_word", dataout, exp_word(8'd3, 8'd200, 8'd7, 8'd7));
    run = 1'b0;
    mode = 1'b0;
    div_n = 32'd1;
    apply(8'h00);
`endif

    // Overflow: full FIFO at completion drops the strobe and sets sticky ovf
    fifo_full = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 4; i++) apply(8'h50 + 8'(i));
    apply(8'h54);
    chk_bit("ov_wr_en", wr_en, 1'b0);
    chk_bit("ov_set", ovf, 1'b1);
    chk_word("ov_word", dataout, exp_word(8'h50, 8'h51, 8'h52, 8'h53));
    apply(8'h55);
    chk_bit("ov_sticky", ovf, 1'b1);
    apply(8'h56);
    apply(8'h57);
    ovf_clr = 1'b1;
    apply(8'h58);
    chk_bit("ov_set_wins", ovf, 1'b1);
    chk_bit("ov_wr_en2", wr_en, 1'b0);
    chk_word("ov_word2", dataout, exp_word(8'h54, 8'h55, 8'h56, 8'h57));
    ovf_clr = 1'b0;
    fifo_full = 1'b0;
    run = 1'b0;
    apply(8'h00);
    chk_bit("ov_still_set", ovf, 1'b1);
    ovf_clr = 1'b1;
    apply(8'h00);
    chk_bit("ov_cleared", ovf, 1'b0);
    ovf_clr = 1'b0;

    // Run dropped after 2 of 4 slots: partial word discarded
    run = 1'b1;
    apply(8'h60);
    apply(8'h61);
    chk_bit("rs_wr_en_a", wr_en, 1'b0);
    run = 1'b0;
    apply(8'h62);
    chk_bit("rs_wr_en_b", wr_en, 1'b0);
    run = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      apply(8'h70 + 8'(i));
      chk_bit($sformatf("rs_wr_en_%0d", i), wr_en, i == 4);
    end
    chk_word("rs_word", dataout, exp_word(8'h70, 8'h71, 8'h72, 8'h73));
    run = 1'b0;
    apply(8'h00);

`ifdef ACQ_PEAK_DET_EN
    // Mode toggled mid-word: restart, then peak mode at div 1 gives min = max = sample
    run = 1'b1;
    apply(8'h90);
    apply(8'h91);
    mode = 1'b1;
    apply(8'h92);
    chk_bit("mt_wr_en_a", wr_en, 1'b0);
    apply(8'h80);
    apply(8'h81);
    chk_bit("mt_wr_en_b", wr_en, 1'b0);
    apply(8'h00);
    chk_bit("mt_wr_en", wr_en, 1'b1);
    chk_word("mt_word", dataout, exp_word(8'h80, 8'h80, 8'h81, 8'h81));
    run = 1'b0;
    mode = 1'b0;
    apply(8'h00);
`endif

    // Asynchronous reset while a strobe is high and a new word is partly filled
    run = 1'b1;
    for (int i = 0; i <= 4; i++) apply(8'ha0 + 8'(i));
    chk_bit("ar_pre_wr_en", wr_en, 1'b1);
    #1 cnt_clr = 1'b0;
    #1;
    chk_word("ar_dataout", dataout, 128'h0);
    chk_bit("ar_wr_en", wr_en, 1'b0);
    chk_bit("ar_ovf", ovf, 1'b0);
    #1 cnt_clr = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      apply(8'hb0 + 8'(i));
      chk_bit($sformatf("ar_post_wr_en_%0d", i), wr_en, i == 4);
    end
    chk_word("ar_post_word", dataout, exp_word(8'hb0, 8'hb1, 8'hb2, 8'hb3));
    run = 1'b0;
    apply(8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
